// File: rtl/branch_target_buffer_sat.sv
// Tagged, direct-mapped branch target buffer with saturating direction counters.
// Lookup is combinational from registered state (fetch stage); training arrives
// from execute and takes effect on the next rising edge.
//
// Ports:
//   clk, arst        clock, asynchronous active-high reset
//   flush            invalidate every entry on the next edge (update dropped)
//   lookup_pc        fetch PC to predict
//   lookup_hit       valid entry with matching tag
//   lookup_taken     hit and counter MSB set
//   predicted_pc     stored target when predicted taken, else lookup_pc + 2**PC_ALIGN
//   update_en        resolved branch present this cycle
//   update_pc        PC of the resolved branch
//   update_taken     resolved direction
//   update_target    resolved target
module branch_target_buffer_sat #(
    parameter int unsigned PC_WIDTH   = 64,
    parameter int unsigned INDEX_BITS = 5,
    parameter int unsigned CNT_BITS   = 2,
    parameter int unsigned PC_ALIGN   = 2
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                flush,
    input  logic [PC_WIDTH-1:0] lookup_pc,
    output logic                lookup_hit,
    output logic                lookup_taken,
    output logic [PC_WIDTH-1:0] predicted_pc,
    input  logic                update_en,
    input  logic [PC_WIDTH-1:0] update_pc,
    input  logic                update_taken,
    input  logic [PC_WIDTH-1:0] update_target
);

    localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
    localparam int unsigned TAG_LSB = PC_ALIGN + INDEX_BITS;
    localparam int unsigned TAG_W   = PC_WIDTH - TAG_LSB;

    localparam logic [CNT_BITS-1:0] CNT_MAX     = CNT_BITS'((2 ** CNT_BITS) - 1);
    localparam logic [CNT_BITS-1:0] CNT_WEAK_T  = CNT_BITS'(2 ** (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] CNT_WEAK_NT = CNT_BITS'((2 ** (CNT_BITS - 1)) - 1);
    localparam logic [PC_WIDTH-1:0] PC_STEP     = PC_WIDTH'(2 ** PC_ALIGN);

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_q [ENTRIES];
    logic [PC_WIDTH-1:0] tgt_q [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q [ENTRIES];

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_W-1:0]      up_tag;
    logic                  up_hit;
    logic [CNT_BITS-1:0]   cnt_cur;
    logic [CNT_BITS-1:0]   cnt_inc;
    logic [CNT_BITS-1:0]   cnt_dec;

    // Alignment bits of the update PC carry no information for this table.
    logic unused_update_pc;
    assign unused_update_pc = ^update_pc;

    // Fetch-side prediction from the current (pre-update) state.
    always_comb begin
        lk_idx       = lookup_pc[TAG_LSB-1:PC_ALIGN];
        lk_tag       = lookup_pc[PC_WIDTH-1:TAG_LSB];
        lookup_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lookup_taken = lookup_hit && cnt_q[lk_idx][CNT_BITS-1];
        predicted_pc = lookup_taken ? tgt_q[lk_idx] : (lookup_pc + PC_STEP);
    end

    // Training-side decode and saturating counter arithmetic.
    always_comb begin
        up_idx  = update_pc[TAG_LSB-1:PC_ALIGN];
        up_tag  = update_pc[PC_WIDTH-1:TAG_LSB];
        up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        cnt_cur = cnt_q[up_idx];
        cnt_inc = (cnt_cur == CNT_MAX) ? cnt_cur : cnt_cur + CNT_BITS'(1);
        cnt_dec = (cnt_cur == '0) ? cnt_cur : cnt_cur - CNT_BITS'(1);
    end

    // Table state; flush clears valid only, keeping counters/tags/targets.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[INDEX_BITS'(i)] <= '0;
                tgt_q[INDEX_BITS'(i)] <= '0;
                cnt_q[INDEX_BITS'(i)] <= CNT_WEAK_NT;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (update_en) begin
            if (up_hit) begin
                if (update_taken) begin
                    cnt_q[up_idx] <= cnt_inc;
                    tgt_q[up_idx] <= update_target;
                end else begin
                    cnt_q[up_idx] <= cnt_dec;
                end
            end else if (update_taken) begin
                // Allocate (or replace an alias) only on a taken miss.
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
                tgt_q[up_idx]   <= update_target;
                cnt_q[up_idx]   <= CNT_WEAK_T;
            end
        end
    end

endmodule

// File: doc/branch_target_buffer_sat.md
Name: branch_target_buffer_sat

Overview:
- Parametrised, tagged, direct-mapped branch target buffer with N-bit saturating direction counters per entry.
- Sits in the fetch stage: combinationally supplies the next-PC prediction for the current fetch PC.
- Trained one cycle later from the execute stage with the resolved outcome of the previous branch.
- Adds over the earlier 2-bit predictor: tag match and valid bits, stored targets, configurable depth, PC width and counter width, allocate-on-taken policy and a pipeline flush.

Parameters:
- PC_WIDTH, 64, width of all PC/target buses.
- INDEX_BITS, 5, log2 of entry count (2**INDEX_BITS entries).
- CNT_BITS, 2, saturating counter width (>=1).
- PC_ALIGN, 2, low PC bits ignored; the sequential PC increment is 2**PC_ALIGN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- arst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous invalidate of all entries.
- lookup_pc  in  PC_WIDTH  fetch PC to predict.
- lookup_hit  out  1  valid entry with matching tag.
- lookup_taken  out  1  hit and counter MSB = 1.
- predicted_pc  out  PC_WIDTH  next fetch PC.
- update_en  in  1  resolved branch present this cycle.
- update_pc  in  PC_WIDTH  PC of the resolved branch.
- update_taken  in  1  actual direction.
- update_target  in  PC_WIDTH  actual branch target.

Behaviour:
- Index = pc[PC_ALIGN+INDEX_BITS-1 : PC_ALIGN].
- Tag = pc[PC_WIDTH-1 : PC_ALIGN+INDEX_BITS].
- Each entry holds: valid, tag, target, and counter (CNT_BITS).
- Lookup is purely combinational from the registered state (zero latency):
  - lookup_hit = valid[idx] && tag[idx] == lookup tag.
  - lookup_taken = lookup_hit && cnt[idx][CNT_BITS-1].
  - predicted_pc = target[idx] if lookup_taken, else lookup_pc + 2**PC_ALIGN (modulo 2**PC_WIDTH, wrap-around silently).
- Reset (arst high, asynchronous): all valid = 0, all counters = 2**(CNT_BITS-1)-1 (weakly not-taken), tags/targets = 0.
  - Consequently after reset lookup_hit = 0, lookup_taken = 0, predicted_pc = lookup_pc + 2**PC_ALIGN.
  - Reset asserted mid-operation discards any in-flight update.
- Update (rising edge, update_en = 1, flush = 0):
  - Hit (valid and tag match):
    - taken: counter saturating +1 (caps at 2**CNT_BITS-1), target <= update_target.
    - not taken: counter saturating -1 (floors at 0), target unchanged.
  - Miss and taken: allocate/replace the entry: valid = 1, tag = update tag, target = update_target, counter = 2**(CNT_BITS-1) (weakly taken).
  - Miss and not taken: no state change (no allocation).
- flush = 1: all valid <= 0 on the next edge; counters, tags and targets are retained. Flush takes priority over a simultaneous update (the update is dropped).
- Lookup and update to the same index in the same cycle: the lookup reflects the pre-update state; the new state is visible from the next cycle.
- Aliasing: a different tag with the same index replaces the entry only on a taken miss.
- CNT_BITS = 1 degenerates to last-outcome prediction: allocate at 1; taken sets 1, not-taken clears 0.
- No X propagation permitted on outputs after reset, even for never-written entries.

Test Plan:
- Reset then lookup_pc = 0x1000 -> lookup_hit = 0, lookup_taken = 0, predicted_pc = 0x1004.
- Update pc = 0x1000, taken, target = 0x2000; next cycle lookup 0x1000 -> hit = 1, taken = 1, predicted_pc = 0x2000.
- Counter saturation (CNT_BITS = 2), after the allocate above:
  - Two more taken updates: counter = 3; one not-taken: counter = 2, predicted_pc still 0x2000.
  - A second not-taken: counter = 1, predicted_pc = 0x1004, hit still 1.
  - Three further not-takens: counter floors at 0.
- Alias, with the entry at 0x1000 present (entry index = (pc >> 2) mod 32):
  - Not-taken update for 0x1080 (same index, different tag) -> 0x1000 entry unchanged.
  - Taken update 0x1080 -> 0x3000 replaces it; lookup 0x1000 -> hit = 0, predicted_pc = 0x1004; lookup 0x1080 -> 0x3000.
- Same-cycle lookup and update on the same index: lookup shows the old prediction that cycle and the new one the next cycle.
- Flush asserted together with a taken update -> all lookups miss next cycle, update dropped.
- arst pulsed mid-update -> all entries invalid immediately, without waiting for a clock edge.
- Lookup 0xFFFF_FFFF_FFFF_FFFC on a miss -> predicted_pc = 0x0.
